// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// response-owner encoding, out-of-range fetch data and the range check helper.
package mem_arb_pkg;

    localparam int unsigned WORD_BYTES = 4;

    localparam logic [31:0] OOR_IDATA_DEFAULT = 32'hdead_beef;

    // Owner of the response slot in the cycle after a grant.
    localparam logic [2:0] OWN_NONE   = 3'd0;
    localparam logic [2:0] OWN_IF_RD  = 3'd1;
    localparam logic [2:0] OWN_DM_RD  = 3'd2;
    localparam logic [2:0] OWN_OOR_IF = 3'd3;
    localparam logic [2:0] OWN_OOR_DM = 3'd4;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } mem_acc_t;

    function automatic logic addr_oor(input logic [31:0] byte_addr,
                                      input int unsigned depth_words);
        return (byte_addr >= (32'(depth_words) * 32'(WORD_BYTES)));
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating grant/stall counters for the unified memory arbiter,
// present only in builds that define MEM_ARB_PERF_EN.
module mem_arb_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic        if_gnt,
    input  logic        dm_gnt,
    output logic [31:0] perf_grants_if,
    output logic [31:0] perf_grants_dm,
    output logic [31:0] perf_stall_if
);

    logic [31:0] grants_if_q, grants_if_d;
    logic [31:0] grants_dm_q, grants_dm_d;
    logic [31:0] stall_if_q,  stall_if_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        logic [31:0] res;
        if (en && (cnt != 32'hffff_ffff)) begin
            res = cnt + 32'd1;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Next-state values for the three counters.
    always_comb begin
        grants_if_d = sat_inc(grants_if_q, if_gnt);
        grants_dm_d = sat_inc(grants_dm_q, dm_gnt);
        stall_if_d  = sat_inc(stall_if_q, if_req & ~if_gnt);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_if_q <= 32'h0;
            grants_dm_q <= 32'h0;
            stall_if_q  <= 32'h0;
        end else begin
            grants_if_q <= grants_if_d;
            grants_dm_q <= grants_dm_d;
            stall_if_q  <= stall_if_d;
        end
    end

    assign perf_grants_if = grants_if_q;
    assign perf_grants_dm = grants_dm_q;
    assign perf_stall_if  = stall_if_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port SRAM between CPU fetch and data ports (data first,
// fetch starvation guard). Define MEM_ARB_PERF_EN to add performance counters.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] OOR_IDATA    = OOR_IDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic [31:0]       dm_addr,
    input  logic [3:0]        dm_wen,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       perf_grants_if,
    output logic [31:0]       perf_grants_dm,
    output logic [31:0]       perf_stall_if
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [2:0]  owner_q, owner_d;
    logic        dm_err_q, dm_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_gnt_s, dm_gnt_s;
    logic        if_oor_s, dm_oor_s;
    logic        if_rvalid_s, dm_rvalid_s;
    mem_acc_t    acc_s;

    assign if_oor_s = addr_oor(if_addr, DEPTH_WORDS);
    assign dm_oor_s = addr_oor(dm_addr, DEPTH_WORDS);

    // Grants are suppressed while reset is asserted so every output reads 0.
    always_comb begin
        dm_gnt_s = 1'b0;
        if_gnt_s = 1'b0;
        if (!rst_n) begin
            dm_gnt_s = 1'b0;
            if_gnt_s = 1'b0;
        end else if (dm_req && (!if_req || (starve_cnt_q < LIMIT_C))) begin
            dm_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            dm_gnt_s = 1'b0;
            if_gnt_s = 1'b0;
        end
    end

    // Counts data grants that overtake a waiting fetch; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt_s) begin
            starve_cnt_d = 4'd0;
        end else if (dm_gnt_s && (starve_cnt_q < LIMIT_C)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Out-of-range accesses never reach the SRAM.
    always_comb begin
        acc_s = '0;
        if (dm_gnt_s && !dm_oor_s) begin
            acc_s.en    = 1'b1;
            acc_s.addr  = dm_addr;
            acc_s.wen   = dm_wen;
            acc_s.wdata = dm_wdata;
        end else if (if_gnt_s && !if_oor_s) begin
            acc_s.en    = 1'b1;
            acc_s.addr  = if_addr;
            acc_s.wen   = 4'h0;
            acc_s.wdata = 32'h0;
        end else begin
            acc_s = '0;
        end
    end

    assign mem_en    = acc_s.en;
    assign mem_addr  = acc_s.addr[ADDR_W+1:2];
    assign mem_wen   = acc_s.wen;
    assign mem_wdata = acc_s.wdata;

    // Tag the response slot for next cycle; writes and idle cycles leave it empty.
    always_comb begin
        owner_d  = OWN_NONE;
        dm_err_d = dm_gnt_s & dm_oor_s;
        if (dm_gnt_s) begin
            if (dm_wen == 4'h0) begin
                owner_d = dm_oor_s ? OWN_OOR_DM : OWN_DM_RD;
            end else begin
                owner_d = OWN_NONE;
            end
        end else if (if_gnt_s) begin
            owner_d = if_oor_s ? OWN_OOR_IF : OWN_IF_RD;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // Route the response to its owner; the other port keeps its last read data.
    always_comb begin
        if_rvalid_s = 1'b0;
        dm_rvalid_s = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (owner_q)
            OWN_IF_RD: begin
                if_rvalid_s = 1'b1;
                if_rdata_d  = mem_rdata;
            end
            OWN_OOR_IF: begin
                if_rvalid_s = 1'b1;
                if_rdata_d  = OOR_IDATA;
            end
            OWN_DM_RD: begin
                dm_rvalid_s = 1'b1;
                dm_rdata_d  = mem_rdata;
            end
            OWN_OOR_DM: begin
                dm_rvalid_s = 1'b1;
                dm_rdata_d  = 32'h0;
            end
            default: begin
                if_rvalid_s = 1'b0;
                dm_rvalid_s = 1'b0;
            end
        endcase
    end

    // Arbiter state and held read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
            owner_q      <= OWN_NONE;
            dm_err_q     <= 1'b0;
            if_rdata_q   <= 32'h0;
            dm_rdata_q   <= 32'h0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            dm_err_q     <= dm_err_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign dm_gnt    = dm_gnt_s;
    assign if_rvalid = if_rvalid_s;
    assign dm_rvalid = dm_rvalid_s;
    assign if_rdata  = if_rdata_d;
    assign dm_rdata  = dm_rdata_d;
    assign dm_err    = dm_err_q;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_gnt         (if_gnt_s),
        .dm_gnt         (dm_gnt_s),
        .perf_grants_if (perf_grants_if),
        .perf_grants_dm (perf_grants_dm),
        .perf_stall_if  (perf_stall_if)
    );
`else
    assign perf_grants_if = 32'h0;
    assign perf_grants_dm = 32'h0;
    assign perf_stall_if  = 32'h0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus random
// traffic compared against a cycle-level reference of the arbitration rules.
module tb_unified_mem_arbiter;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LIMIT = 4;

    logic        clk, rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_gnt, dm_rvalid, dm_err;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wen;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] perf_grants_if, perf_grants_dm, perf_stall_if;

    logic [31:0] sram    [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    int          total, bad;
    int unsigned starve;
    logic        exp_if_rv, exp_dm_rv, exp_dm_err;
    logic [31:0] exp_if_rdata, exp_dm_rdata;
    logic        eg_dm, eg_if, obs_dm;
    logic [7:0]  pat;
    logic        p_if, p_dm;

    unified_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .perf_grants_if(perf_grants_if), .perf_grants_dm(perf_grants_dm),
        .perf_stall_if(perf_stall_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Write-first single-port SRAM model.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen != 4'h0) begin
                sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wen);
                mem_rdata      <= merge(sram[mem_addr], mem_wdata, mem_wen);
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    function automatic logic in_range(input logic [31:0] a);
        return (a < 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 1023));
        else a = 32'($urandom_range(0, 255));
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        starve       = 0;
        exp_if_rv    = 1'b0;
        exp_dm_rv    = 1'b0;
        exp_dm_err   = 1'b0;
        exp_if_rdata = 32'h0;
        exp_dm_rdata = 32'h0;
    endtask

    // Called just after inputs are driven at a falling edge; returns after the rising edge.
    task automatic step();
        logic        d_in, i_in, nx_if_rv, nx_dm_rv, nx_err;
        logic [31:0] nx_if_rdata, nx_dm_rdata;
        #1;
        eg_dm = dm_req && (!if_req || (starve < LIMIT));
        eg_if = !eg_dm && if_req;
        d_in  = in_range(dm_addr);
        i_in  = in_range(if_addr);
        obs_dm = dm_gnt;
        chk("dm_gnt", 32'(dm_gnt), 32'(eg_dm));
        chk("if_gnt", 32'(if_gnt), 32'(eg_if));
        chk("mem_en", 32'(mem_en), 32'((eg_dm && d_in) || (eg_if && i_in)));
        if (eg_dm && d_in) begin
            chk("mem_addr_dm", 32'(mem_addr), dm_addr / 4);
            chk("mem_wen_dm", 32'(mem_wen), 32'(dm_wen));
            chk("mem_wdata_dm", mem_wdata, dm_wdata);
        end
        if (eg_if && i_in) begin
            chk("mem_addr_if", 32'(mem_addr), if_addr / 4);
            chk("mem_wen_if", 32'(mem_wen), 32'h0);
        end
        chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
        chk("if_rdata", if_rdata, exp_if_rdata);
        chk("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm_rv));
        chk("dm_rdata", dm_rdata, exp_dm_rdata);
        chk("dm_err", 32'(dm_err), 32'(exp_dm_err));

        nx_if_rv = 1'b0; nx_dm_rv = 1'b0; nx_err = 1'b0;
        nx_if_rdata = exp_if_rdata; nx_dm_rdata = exp_dm_rdata;
        if (eg_dm) begin
            nx_err = !d_in;
            if (dm_wen == 4'h0) begin
                nx_dm_rv    = 1'b1;
                nx_dm_rdata = d_in ? ref_mem[dm_addr / 4] : 32'h0;
            end else if (d_in) begin
                ref_mem[dm_addr / 4] = merge(ref_mem[dm_addr / 4], dm_wdata, dm_wen);
            end
        end
        if (eg_if) begin
            nx_if_rv    = 1'b1;
            nx_if_rdata = i_in ? ref_mem[if_addr / 4] : 32'hdeadbeef;
        end
        if (!if_req || eg_if) starve = 0;
        else if (eg_dm && starve < LIMIT) starve++;

        @(posedge clk);
        exp_if_rv = nx_if_rv; exp_dm_rv = nx_dm_rv; exp_dm_err = nx_err;
        exp_if_rdata = nx_if_rdata; exp_dm_rdata = nx_dm_rdata;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"}, 32'(if_gnt), 32'h0);
        chk({tag, "_dm_gnt"}, 32'(dm_gnt), 32'h0);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'h0);
        chk({tag, "_dm_rvalid"}, 32'(dm_rvalid), 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
        chk({tag, "_dm_err"}, 32'(dm_err), 32'h0);
        chk({tag, "_mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        chk({tag, "_mem_wen"}, 32'(mem_wen), 32'h0);
        chk({tag, "_perf"}, perf_grants_if | perf_grants_dm | perf_stall_if, 32'h0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_addr = 32'h0; dm_wen = 4'h0; dm_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    <= (32'(i) * 32'h0101_0101) ^ 32'h5a00_0000;
            ref_mem[i]  = (32'(i) * 32'h0101_0101) ^ 32'h5a00_0000;
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Contention: fetch waits behind four data grants, then drops after its grant.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_addr = 32'h80; dm_wen = 4'h0;
        for (int c = 0; c < 8; c++) begin
            step();
            pat[7-c] = obs_dm;
            @(negedge clk);
            if (eg_if) if_req = 1'b0;
            if (eg_dm) dm_addr = dm_addr + 32'h4;
        end
        chk("grant_pattern", 32'(pat), 32'h0000_00f7);
`ifdef MEM_ARB_PERF_EN
        chk("perf_grants_dm", perf_grants_dm, 32'd7);
        chk("perf_grants_if", perf_grants_if, 32'd1);
        chk("perf_stall_if", perf_stall_if, 32'd4);
`else
        chk("perf_tied_off", perf_grants_if | perf_grants_dm | perf_stall_if, 32'h0);
`endif
        dm_req = 1'b0;
        step();
        @(negedge clk);

        // Back-to-back fetches.
        for (int k = 0; k < 3; k++) begin
            if_req = 1'b1; if_addr = 32'(k * 4);
            step();
            @(negedge clk);
        end
        if_req = 1'b0;
        step();
        @(negedge clk);

        // Write then read the same word on consecutive cycles.
        dm_req = 1'b1; dm_addr = 32'h200; dm_wen = 4'hf; dm_wdata = 32'd6;
        step();
        @(negedge clk);
        dm_wen = 4'h0;
        step();
        #1 chk("raw_rdata", dm_rdata, 32'd6);
        @(negedge clk);
        dm_req = 1'b0;

        // Out-of-range write and fetch.
        dm_req = 1'b1; dm_addr = 32'h1000; dm_wen = 4'hf; dm_wdata = 32'h1234_5678;
        step();
        #1 chk("oor_dm_err", 32'(dm_err), 32'h1);
        @(negedge clk);
        dm_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        step();
        #1 chk("oor_if_rdata", if_rdata, 32'hdeadbeef);
        @(negedge clk);
        if_req = 1'b0;
        step();
        @(negedge clk);

        // Random traffic honouring hold-until-granted.
        p_if = 1'b0; p_dm = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!p_if) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = rand_addr();
            end
            if (!p_dm) begin
                dm_req   = ($urandom_range(0, 3) != 0);
                dm_addr  = rand_addr();
                dm_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                dm_wdata = $urandom;
            end
            step();
            p_if = if_req && !eg_if;
            p_dm = dm_req && !eg_dm;
            @(negedge clk);
        end

        // Reset in the response cycle of a data read.
        if_req = 1'b0;
        dm_req = 1'b1; dm_addr = 32'h10; dm_wen = 4'h0;
        step();
        #1;
        dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        if_req = 1'b0;
        step();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
